// File: rtl/ppu_vga_scanout.sv
`default_nettype none
// ============================================================================
// ppu_vga_scanout : PPU pixel stream -> ping-pong line buffers -> 640x480 VGA
// Rev 1.0 | optional border fill: define SCANOUT_BORDER_EN
// ============================================================================
module ppu_vga_scanout #(
    parameter int unsigned H_OFFSET     = 64,
    parameter logic [5:0]  BORDER_COLOR = 6'h0F
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic [5:0] VGA_STREAM_DATA,
    input  logic [7:0] PPU_PTR_X,
    input  logic [7:0] PPU_PTR_Y,
    input  logic       VGA_STREAM_READY,
    input  logic       STAT_CLR,
    output logic [5:0] VGA_PIX,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_DE,
    output logic       OVERRUN,
    output logic       UNDERRUN
);

    localparam logic [9:0] c_H_LAST    = 10'd799;
    localparam logic [9:0] c_V_LAST    = 10'd524;
    localparam logic [9:0] c_H_ACTIVE  = 10'd640;
    localparam logic [9:0] c_V_ACTIVE  = 10'd480;
    localparam logic [9:0] c_HS_START  = 10'd656;
    localparam logic [9:0] c_HS_END    = 10'd751;
    localparam logic [9:0] c_VS_START  = 10'd490;
    localparam logic [9:0] c_VS_END    = 10'd491;
    localparam logic [9:0] c_PIC_START = 10'(H_OFFSET);
    localparam logic [9:0] c_PIC_END   = 10'(H_OFFSET + 512);

`ifdef SCANOUT_BORDER_EN
    localparam logic       c_BORDER_EN = 1'b1;
`else
    localparam logic       c_BORDER_EN = 1'b0;
`endif
    localparam logic [5:0] c_BORDER_PIX = BORDER_COLOR & {6{c_BORDER_EN}};

    // Raster and control state
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       wsel_q, wsel_d;      // buffer currently owned by the writer
    logic       full_q, full_d;
    logic       valid_q, valid_d;
    logic       ovr_q, ovr_d;
    logic       und_q, und_d;

    // Stage 1 (aligned with RAM read data) and stage 2 (output) registers
    logic       pic1_q, act1_q, hs1_q, vs1_q, valid1_q;
    logic [5:0] rdata_q;
    logic [5:0] pix_q, pix_d;
    logic       hs_q, vs_q, de_q, de_d;

    logic [5:0] buf0_mem [256];
    logic [5:0] buf1_mem [256];

    logic       w_active, w_pic, w_hs, w_vs;
    logic       w_swap, w_beat, w_wr_en, w_line_done, w_drop, w_underrun_evt;
    logic [7:0] w_rd_addr;

    assign w_active  = (h_q < c_H_ACTIVE) && (v_q < c_V_ACTIVE);
    assign w_pic     = (h_q >= c_PIC_START) && (h_q < c_PIC_END) && (v_q < c_V_ACTIVE);
    assign w_hs      = !((h_q >= c_HS_START) && (h_q <= c_HS_END));
    assign w_vs      = !((v_q >= c_VS_START) && (v_q <= c_VS_END));
    assign w_rd_addr = 8'((h_q - c_PIC_START) >> 1);

    // Odd lines never swap, so they replay the line fetched for the even one
    assign w_swap         = (h_q == 10'd0) && !v_q[0] && (v_q < c_V_ACTIVE);
    assign w_beat         = VGA_STREAM_READY && (PPU_PTR_Y < 8'd240);
    assign w_wr_en        = w_beat && !full_q;
    assign w_line_done    = w_wr_en && (PPU_PTR_X == 8'hFF);
    assign w_drop         = w_beat && full_q;
    assign w_underrun_evt = w_swap && !full_q && valid_q;

    always_comb begin
        h_d     = (h_q == c_H_LAST) ? 10'd0 : h_q + 10'd1;
        v_d     = v_q;
        wsel_d  = wsel_q;
        full_d  = full_q;
        valid_d = valid_q;
        if (h_q == c_H_LAST) begin
            v_d = (v_q == c_V_LAST) ? 10'd0 : v_q + 10'd1;
        end
        // Swap decides on the registered FULL, so a line finishing in the
        // swap cycle is picked up only at the next even line.
        if (w_swap && full_q) begin
            wsel_d  = ~wsel_q;
            full_d  = 1'b0;
            valid_d = 1'b1;
        end
        if (w_line_done) begin
            full_d = 1'b1;
        end
        ovr_d = w_drop | (ovr_q & ~STAT_CLR);
        und_d = w_underrun_evt | (und_q & ~STAT_CLR);
    end

    always_comb begin
        pix_d = 6'h00;
        de_d  = 1'b0;
        if (pic1_q) begin
            de_d  = 1'b1;
            pix_d = valid1_q ? rdata_q : 6'h00;
        end else if (act1_q) begin
            de_d  = c_BORDER_EN;
            pix_d = c_BORDER_PIX;
        end
    end

    // Line buffers: no reset, reader always uses the buffer the writer does not own
    always_ff @(posedge VGA_CLK) begin
        if (w_wr_en && !wsel_q) begin
            buf0_mem[PPU_PTR_X] <= VGA_STREAM_DATA;
        end
        if (w_wr_en && wsel_q) begin
            buf1_mem[PPU_PTR_X] <= VGA_STREAM_DATA;
        end
        rdata_q <= wsel_q ? buf0_mem[w_rd_addr] : buf1_mem[w_rd_addr];
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            wsel_q   <= 1'b0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
            pic1_q   <= 1'b0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            valid1_q <= 1'b0;
            pix_q    <= 6'h00;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            de_q     <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            wsel_q   <= wsel_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
            pic1_q   <= w_pic;
            act1_q   <= w_active;
            hs1_q    <= w_hs;
            vs1_q    <= w_vs;
            valid1_q <= valid_q;
            pix_q    <= pix_d;
            hs_q     <= hs1_q;
            vs_q     <= vs1_q;
            de_q     <= de_d;
        end
    end

    assign VGA_PIX  = pix_q;
    assign VGA_HS   = hs_q;
    assign VGA_VS   = vs_q;
    assign VGA_DE   = de_q;
    assign OVERRUN  = ovr_q;
    assign UNDERRUN = und_q;

endmodule

`default_nettype wire
